burst_mem_responder: RTL and testbench

BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

---
 rtl/rv32i_types.sv | 6 +
 rtl/burst_mem_responder_if.sv | 19 +
 rtl/burst_mem_array.sv | 34 +++
 rtl/burst_mem_responder.sv | 117 +++++++++++
 tb/tb_burst_mem_responder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared memory-burst geometry: a 256-bit line moves as four 64-bit beats.
package rv32i_types;
    localparam int pmem_burst_len  = 4;
    localparam int pmem_beat_width = 64;
    localparam int line_width      = pmem_burst_len * pmem_beat_width;
endpackage

// File: rtl/burst_mem_responder_if.sv
// Burst memory bus: the initiator holds read/write until the last resp beat.
interface burst_mem_responder_if import rv32i_types::*; ();
    logic                       pmem_read;
    logic                       pmem_write;
    logic [31:0]                pmem_address;
    logic [pmem_beat_width-1:0] pmem_wdata;
    logic [pmem_beat_width-1:0] pmem_rdata;
    logic                       pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/burst_mem_array.sv
// Beat-granular line store, one shared port, registered read that holds when idle.
module burst_mem_array import rv32i_types::*; #(
    parameter int LINE_IDX_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we_i,
    input  logic                       re_i,
    input  logic [LINE_IDX_W+1:0]      addr_i,
    input  logic [pmem_beat_width-1:0] wdata_i,
    output logic [pmem_beat_width-1:0] rdata_o
);
    localparam int DEPTH = (2 ** LINE_IDX_W) * pmem_burst_len;

    logic [pmem_beat_width-1:0] mem_q [DEPTH];
    logic [pmem_beat_width-1:0] rdata_q;

    // Storage deliberately has no reset so contents survive an aborted burst.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/burst_mem_responder.sv
// Fixed-latency burst memory model: accept, wait LATENCY cycles, stream 4 beats.
module burst_mem_responder import rv32i_types::*; #(
    parameter int LATENCY    = 10,
    parameter int LINE_IDX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    burst_mem_responder_if.slave bus,
    output logic                 proto_err
);
    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_e;

    localparam int         MEM_AW    = LINE_IDX_W + 2;
    localparam logic [1:0] LAST_BEAT = 2'(pmem_burst_len - 1);

    state_e                     state_q;
    logic                       op_wr_q;
    logic [LINE_IDX_W-1:0]      line_q;
    logic [7:0]                 cnt_q;
    logic [1:0]                 beat_q;
    logic                       resp_q;
    logic                       err_q;

    logic                       req_any;
    logic                       req_ok;
    logic                       mem_we;
    logic                       mem_re;
    logic [MEM_AW-1:0]          mem_addr;
    logic [pmem_beat_width-1:0] mem_rdata;
    logic                       unused_addr_bits;

    assign req_any = bus.pmem_read | bus.pmem_write;
    assign req_ok  = op_wr_q ? (bus.pmem_write & ~bus.pmem_read)
                             : (bus.pmem_read & ~bus.pmem_write);
    assign unused_addr_bits = ^{bus.pmem_address[31:LINE_IDX_W+5], bus.pmem_address[4:0]};

    // Reads prefetch one beat ahead so the registered array output lines up with resp.
    always_comb begin
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = {line_q, beat_q};
        if (state_q == BURST) begin
            if (op_wr_q) begin
                mem_we = ~rst;
            end else if (beat_q != LAST_BEAT) begin
                mem_re   = 1'b1;
                mem_addr = {line_q, beat_q + 2'd1};
            end
        end else if (state_q == WAIT && cnt_q == '0 && !op_wr_q) begin
            mem_re   = 1'b1;
            mem_addr = {line_q, 2'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_wr_q <= 1'b0;
            line_q  <= '0;
            cnt_q   <= '0;
            beat_q  <= '0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        // A simultaneous read+write is flagged and served as a read.
                        op_wr_q <= ~bus.pmem_read;
                        line_q  <= bus.pmem_address[LINE_IDX_W+4:5];
                        cnt_q   <= 8'(LATENCY - 1);
                        state_q <= WAIT;
                        if (bus.pmem_read && bus.pmem_write) err_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!req_ok) err_q <= 1'b1;
                    if (cnt_q == '0) begin
                        state_q <= BURST;
                        resp_q  <= 1'b1;
                        beat_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                BURST: begin
                    if (!req_ok) err_q <= 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_q <= DONE;
                        resp_q  <= 1'b0;
                        beat_q  <= '0;
                    end else begin
                        beat_q <= beat_q + 2'd1;
                    end
                end
                DONE: begin
                    if (!req_any) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    burst_mem_array #(.LINE_IDX_W(LINE_IDX_W)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (bus.pmem_wdata),
        .rdata_o (mem_rdata)
    );

    assign bus.pmem_resp  = resp_q;
    assign bus.pmem_rdata = mem_rdata;
    assign proto_err      = err_q;
endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench: a LATENCY=10 and a LATENCY=1 responder driven through one shared stimulus set.
module tb_burst_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        d_read, d_write;
    logic [31:0] d_addr;
    logic [63:0] d_wdata;
    logic        proto_err, proto_err1;
    logic        resp, err;
    logic [63:0] rdata;

    burst_mem_responder_if bus ();
    burst_mem_responder_if bus1 ();

    assign bus.pmem_read     = !sel && d_read;
    assign bus.pmem_write    = !sel && d_write;
    assign bus.pmem_address  = d_addr;
    assign bus.pmem_wdata    = d_wdata;
    assign bus1.pmem_read    = sel && d_read;
    assign bus1.pmem_write   = sel && d_write;
    assign bus1.pmem_address = d_addr;
    assign bus1.pmem_wdata   = d_wdata;

    assign resp  = sel ? bus1.pmem_resp  : bus.pmem_resp;
    assign rdata = sel ? bus1.pmem_rdata : bus.pmem_rdata;
    assign err   = sel ? proto_err1      : proto_err;

    burst_mem_responder #(.LATENCY(10), .LINE_IDX_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .proto_err(proto_err)
    );
    burst_mem_responder #(.LATENCY(1), .LINE_IDX_W(8)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .proto_err(proto_err1)
    );

    localparam logic [255:0] L2 = {64'h3, 64'h2, 64'h1, 64'h0};
    localparam logic [255:0] LA = {64'hAAAA_AAAA_AAAA_AAA3, 64'hAAAA_AAAA_AAAA_AAA2,
                                   64'hAAAA_AAAA_AAAA_AAA1, 64'hAAAA_AAAA_AAAA_AAA0};
    localparam logic [255:0] LC = {64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002,
                                   64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0000};
    localparam logic [255:0] LMIX = {64'hAAAA_AAAA_AAAA_AAA3, 64'hAAAA_AAAA_AAAA_AAA2,
                                     64'hBBBB_BBBB_BBBB_BBB1, 64'hBBBB_BBBB_BBBB_BBB0};

    typedef struct {
        bit           sel;
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wline;
        logic [255:0] exp;
        bit           exp_err;
    } vec_t;

    vec_t vecs [10];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Called right after the acceptance edge; lands #1 after the first resp edge.
    task automatic wait_resp(input string name, input int exp_lat);
        int lat = 0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk); #1;
            if (resp) begin
                lat = c;
                break;
            end
        end
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic beats(input string name, input bit wmode, input logic [255:0] wline,
                         input logic [255:0] exp);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (wmode) d_wdata = wline[64*k +: 64];
            chk($sformatf("%s resp%0d", name, k), 64'(resp), 64'd1);
            if (!wmode) chk($sformatf("%s beat%0d", name, k), rdata, exp[64*k +: 64]);
        end
    endtask

    task automatic txn(input string name, input bit s, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [255:0] wline,
                       input logic [255:0] exp, input bit exp_err);
        bit wmode;
        wmode = wr && !rd;
        @(negedge clk);
        sel = s; d_read = rd; d_write = wr; d_addr = addr; d_wdata = wline[63:0];
        @(posedge clk); #1;
        d_addr = addr ^ 32'h0000_1FE0;
        wait_resp(name, s ? 1 : 10);
        beats(name, wmode, wline, exp);
        @(posedge clk); #1;
        chk({name, " resp after"}, 64'(resp), 64'd0);
        if (!wmode) chk({name, " rdata hold"}, rdata, exp[255:192]);
        chk({name, " proto_err"}, 64'(err), 64'(exp_err));
        d_read = 1'b0; d_write = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        int gap;
        vecs[0] = '{0, 0, 1, 32'h0000_0040, L2, '0, 0};
        vecs[1] = '{0, 1, 0, 32'h0000_0040, '0, L2, 0};
        vecs[2] = '{0, 0, 1, 32'h0000_0060, LA, '0, 0};
        vecs[3] = '{0, 1, 0, 32'h0000_0060, '0, LA, 0};
        vecs[4] = '{0, 1, 0, 32'h0001_0040, '0, L2, 0};
        vecs[5] = '{0, 0, 1, 32'h0000_1FE0, LC, '0, 0};
        vecs[6] = '{0, 1, 0, 32'h0000_1FE0, '0, LC, 0};
        vecs[7] = '{1, 0, 1, 32'h0000_0040, L2, '0, 0};
        vecs[8] = '{1, 0, 1, 32'h0000_0060, LA, '0, 0};
        vecs[9] = '{1, 1, 0, 32'h0000_0060, '0, LA, 0};

        rst = 1'b1; sel = 1'b0; d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset resp",       64'(bus.pmem_resp),  64'd0);
        chk("reset rdata",      bus.pmem_rdata,      64'd0);
        chk("reset proto_err",  64'(proto_err),      64'd0);
        chk("reset resp1",      64'(bus1.pmem_resp), 64'd0);
        chk("reset rdata1",     bus1.pmem_rdata,     64'd0);
        chk("reset proto_err1", 64'(proto_err1),     64'd0);
        rst = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 10; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                vecs[i].wline, vecs[i].exp, vecs[i].exp_err);
        end

        // Reset lands during write beat 2: beats 0-1 stick, 2-3 keep the old line.
        @(negedge clk);
        sel = 1'b0; d_write = 1'b1; d_addr = 32'h0000_0060; d_wdata = 64'hBBBB_BBBB_BBBB_BBB0;
        @(posedge clk);
        wait_resp("abort", 10);
        chk("abort resp0", 64'(resp), 64'd1);
        @(posedge clk); #1;
        d_wdata = 64'hBBBB_BBBB_BBBB_BBB1;
        chk("abort resp1", 64'(resp), 64'd1);
        @(posedge clk); #1;
        d_wdata = 64'hBBBB_BBBB_BBBB_BBB2;
        chk("abort resp2", 64'(resp), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort resp dropped", 64'(resp), 64'd0);
        chk("abort rdata reset",  rdata,     64'd0);
        rst = 1'b0; d_write = 1'b0;
        @(posedge clk);
        txn("abort readback", 0, 1, 0, 32'h0000_0060, '0, LMIX, 0);

        // Request dropped during WAIT: burst still runs to completion, error flagged.
        @(negedge clk);
        sel = 1'b0; d_read = 1'b1; d_addr = 32'h0000_0040;
        @(posedge clk); #1;
        d_read = 1'b0;
        wait_resp("drop", 10);
        beats("drop", 0, '0, L2);
        @(posedge clk); #1;
        chk("drop resp after", 64'(resp), 64'd0);
        chk("drop proto_err",  64'(err),  64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);

        // Read and write together: served as a read, error sticky until reset.
        txn("both", 0, 1, 1, 32'h0000_0040, '0, L2, 1);
        txn("sticky", 0, 1, 0, 32'h0000_0060, '0, LMIX, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("err cleared", 64'(proto_err), 64'd0);
        rst = 1'b0;
        @(posedge clk);

        // LATENCY=1 back-to-back: request dips for one cycle, then re-raised.
        @(negedge clk);
        sel = 1'b1; d_read = 1'b1; d_write = 1'b0; d_addr = 32'h0000_0040;
        @(posedge clk);
        wait_resp("b2b first", 1);
        beats("b2b first", 0, '0, L2);
        gap = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (resp) break;
            gap++;
            if (gap == 1) d_read = 1'b0;
            else if (gap == 2) begin
                d_read = 1'b1;
                d_addr = 32'h0000_0060;
            end
        end
        chk("b2b gap", 64'(gap), 64'd3);
        beats("b2b second", 0, '0, LA);
        @(posedge clk); #1;
        d_read = 1'b0;
        chk("b2b resp after", 64'(resp), 64'd0);
        chk("b2b proto_err",  64'(err),  64'd0);
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
